eeprom_ram_arbiter: RTL

Shares the single byte-wide backing RAM of the serial EEPROM emulation between two requesters: the EEPROM core's RAM port and the host save-file port used to load and store battery saves. It arbitrates round-robin, sequences one memory transaction at a time, and holds each requester's completion level until that requester releases its request, which makes it safe for the clock-enable-gated EEPROM core. It also keeps a dirty flag for save write-back and a sticky timeout error flag.

---
 rtl/eeprom_ram_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/eeprom_ram_arbiter.sv
// eeprom_ram_arbiter: shares one byte-wide RAM between the EEPROM core and the host save port.
// Latency: request seen in IDLE -> mem_req next cycle; done one cycle after mem_ack (or after TIMEOUT).
// Backpressure: requests are levels held until done; done is held until the requester drops its request.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ee_addr/rd/wr/wdata          EEPROM-core request; ee_rdata/ee_done returned
//   host_addr/rd/wr/wdata        host save-file request; host_rdata/host_done returned
//   dirty_clr, err_clr           single-cycle clear pulses for dirty / err
//   dirty, err, busy             status: core write seen, memory timeout seen, transaction in progress
//   mem_addr/wdata/we/req        memory request, stable for the whole BUSY phase
//   mem_rdata, mem_ack           memory read data and single-cycle acknowledge
module eeprom_ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ee_addr,
  input  logic              ee_rd,
  input  logic              ee_wr,
  input  logic [7:0]        ee_wdata,
  output logic [7:0]        ee_rdata,
  output logic              ee_done,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_done,
  input  logic              dirty_clr,
  input  logic              err_clr,
  output logic              dirty,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic {REQ_EE = 1'b0, REQ_HOST = 1'b1} req_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t            state_q, state_d;
  req_t              gnt_q, gnt_d;
  req_t              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic [7:0]        ee_rdata_q, ee_rdata_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic              dirty_q, dirty_d;
  logic              err_q, err_d;

  logic ee_pend, host_pend, gnt_pend, timeout_hit, dirty_set, err_set;
  req_t pick;

  assign ee_pend   = ee_rd | ee_wr;
  assign host_pend = host_rd | host_wr;
  assign gnt_pend  = (gnt_q == REQ_EE) ? ee_pend : host_pend;
  // cnt_q counts completed BUSY cycles, so this is the TIMEOUT-th BUSY cycle
  assign timeout_hit = (cnt_q + 16'd1) >= TO_LIMIT;

  // A tie goes to whichever side was not served last
  always_comb begin
    pick = REQ_EE;
    if (ee_pend && host_pend) begin
      pick = (last_q == REQ_HOST) ? REQ_EE : REQ_HOST;
    end else if (host_pend) begin
      pick = REQ_HOST;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    done_d       = done_q;
    ee_rdata_d   = ee_rdata_q;
    host_rdata_d = host_rdata_q;
    dirty_set    = 1'b0;
    err_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ee_pend || host_pend) begin
          state_d = S_BUSY;
          gnt_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (pick == REQ_EE) begin
            addr_d  = ee_addr;
            wdata_d = ee_wdata;
            we_d    = ee_wr;
          end else begin
            addr_d  = host_addr;
            wdata_d = host_wdata;
            we_d    = host_wr;
          end
        end
      end

      S_BUSY: begin
        if (cnt_q < TO_LIMIT) cnt_d = cnt_q + 16'd1;
        // Once the owner lets go, the memory cycle finishes but is never reported
        if (!gnt_pend) abort_d = 1'b1;
        if (mem_ack) begin
          state_d = S_DONE;
          done_d  = gnt_pend && !abort_q;
          if (!we_q) begin
            if (gnt_q == REQ_EE) ee_rdata_d = mem_rdata;
            else                 host_rdata_d = mem_rdata;
          end else if (gnt_q == REQ_EE) begin
            dirty_set = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          done_d  = gnt_pend && !abort_q;
          err_set = 1'b1;
          if (gnt_q == REQ_EE) ee_rdata_d = 8'hFF;
          else                 host_rdata_d = 8'hFF;
        end
      end

      S_DONE: begin
        // An aborted transaction passes through here for exactly one cycle
        if (!done_q || !gnt_pend) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Set has priority over a simultaneous clear
    dirty_d = dirty_set | (dirty_q & ~dirty_clr);
    err_d   = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= REQ_EE;
      last_q       <= REQ_HOST;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
      ee_rdata_q   <= 8'hFF;
      host_rdata_q <= 8'h00;
      dirty_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      ee_rdata_q   <= ee_rdata_d;
      host_rdata_q <= host_rdata_d;
      dirty_q      <= dirty_d;
      err_q        <= err_d;
    end
  end

  assign mem_req    = (state_q == S_BUSY);
  assign busy       = (state_q != S_IDLE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = mem_req & we_q;
  assign ee_done    = done_q & (gnt_q == REQ_EE);
  assign host_done  = done_q & (gnt_q == REQ_HOST);
  assign ee_rdata   = ee_rdata_q;
  assign host_rdata = host_rdata_q;
  assign dirty      = dirty_q;
  assign err        = err_q;

endmodule
